// File: rtl/add_seq_if.sv
// Handshake and operand/result bundle between a wide-operand requester and
// the byte-serial add/subtract sequencer.
interface add_seq_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a_word;
    logic [W-1:0] b_word;
    logic         abort;
    logic         busy;
    logic         done;
    logic         result_valid;
    logic [W-1:0] sum_word;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, cin, a_word, b_word, abort,
        input  busy, done, result_valid, sum_word, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a_word, b_word, abort,
        output busy, done, result_valid, sum_word, cout, ovf
    );
endinterface

// File: rtl/add_seq_ctrl.sv
// Byte-serial wide add/subtract sequencer. One 8-bit prefix adder is reused
// once per byte, LSB first, with the inter-byte carry held in a register.

// 8-bit Kogge-Stone prefix adder with carry-in.
module add_seq_prefix8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic [7:0] g0_s, p0_s, g1_s, p1_s, g2_s, p2_s, g3_s, p3_s;
    logic [8:0] c_s;

    assign g0_s = a & b;
    assign p0_s = a ^ b;

    // Three prefix levels (span 1, 2, 4) build group generate/propagate.
    for (genvar i = 0; i < 8; i++) begin : g_lvl
        if (i >= 1) begin : g_l1
            assign g1_s[i] = g0_s[i] | (p0_s[i] & g0_s[i-1]);
            assign p1_s[i] = p0_s[i] & p0_s[i-1];
        end else begin : g_l1p
            assign g1_s[i] = g0_s[i];
            assign p1_s[i] = p0_s[i];
        end
        if (i >= 2) begin : g_l2
            assign g2_s[i] = g1_s[i] | (p1_s[i] & g1_s[i-2]);
            assign p2_s[i] = p1_s[i] & p1_s[i-2];
        end else begin : g_l2p
            assign g2_s[i] = g1_s[i];
            assign p2_s[i] = p1_s[i];
        end
        if (i >= 4) begin : g_l3
            assign g3_s[i] = g2_s[i] | (p2_s[i] & g2_s[i-4]);
            assign p3_s[i] = p2_s[i] & p2_s[i-4];
        end else begin : g_l3p
            assign g3_s[i] = g2_s[i];
            assign p3_s[i] = p2_s[i];
        end
        // Carry into bit i+1 folds the external carry-in through the group.
        assign c_s[i+1] = g3_s[i] | (p3_s[i] & ci);
    end

    assign c_s[0] = ci;
    assign s      = p0_s ^ c_s[7:0];
    assign co     = c_s[8];
endmodule

module add_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic      clk,
    input  logic      rst,
    add_seq_if.slave  bus
);
    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [IDXW-1:0] idx_r;
    logic [W-1:0]   a_r;
    logic [W-1:0]   b_r;
    logic           sub_r;
    logic           carry_r;
    logic           busy_r;
    logic           done_r;
    logic           rv_r;
    logic [W-1:0]   sum_r;
    logic           cout_r;
    logic           ovf_r;

    logic [7:0]     a_byte_s;
    logic [7:0]     b_byte_s;
    logic [7:0]     b_eff_s;
    logic [7:0]     sum_byte_s;
    logic           co_s;

    assign a_byte_s = a_r[{idx_r, 3'b000} +: 8];
    assign b_byte_s = b_r[{idx_r, 3'b000} +: 8];
    // Subtraction is A + ~B + 1; the +1 is preloaded into the carry register.
    assign b_eff_s  = b_byte_s ^ {8{sub_r}};

    add_seq_prefix8 u_adder (
        .a  (a_byte_s),
        .b  (b_eff_s),
        .ci (carry_r),
        .s  (sum_byte_s),
        .co (co_s)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            idx_r   <= {IDXW{1'b0}};
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rv_r    <= 1'b0;
            sum_r   <= {W{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // abort is irrelevant here; start alone decides.
                    if (bus.start) begin
                        a_r     <= bus.a_word;
                        b_r     <= bus.b_word;
                        sub_r   <= bus.sub;
                        carry_r <= bus.sub ? 1'b1 : bus.cin;
                        idx_r   <= {IDXW{1'b0}};
                        rv_r    <= 1'b0;
                        sum_r   <= {W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_ADD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    if (bus.abort) begin
                        // Partial sum is left as is; cout/ovf keep old values.
                        idx_r   <= {IDXW{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        sum_r[{idx_r, 3'b000} +: 8] <= sum_byte_s;
                        carry_r <= co_s;
                        if (idx_r == LAST_IDX) begin
                            // Flags are loaded with the final byte so they are
                            // already valid in the cycle done is high.
                            cout_r  <= co_s;
                            ovf_r   <= (a_byte_s[7] == b_eff_s[7]) &&
                                       (sum_byte_s[7] != a_byte_s[7]);
                            done_r  <= 1'b1;
                            idx_r   <= {IDXW{1'b0}};
                            state_r <= ST_DONE;
                        end else begin
                            idx_r   <= idx_r + IDXW'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Completion wins over abort in this cycle.
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    rv_r    <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    idx_r   <= {IDXW{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.result_valid = rv_r;
    assign bus.sum_word     = sum_r;
    assign bus.cout         = cout_r;
    assign bus.ovf          = ovf_r;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: arithmetic reference model plus
// directed literal cases and randomized traffic.
module tb_add_seq_ctrl;
    localparam int N = 4;
    localparam int W = 8 * N;
    localparam longint S_MAX = (longint'(1) <<< (W - 1)) - longint'(1);
    localparam longint S_MIN = -(longint'(1) <<< (W - 1));

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    bit   chk_en;

    add_seq_if #(.NBYTES(N)) bus ();

    add_seq_ctrl #(.NBYTES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Returns {cout, ovf, sum} from plain wide integer arithmetic.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s, input logic c);
        longint unsigned ua, ub, us;
        longint sa, sb, ss;
        logic co, ov;
        ua = 64'(a);
        ub = 64'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            us = ua - ub;
            co = (ua >= ub);
            ss = sa - sb;
        end else begin
            us = ua + ub + 64'(c);
            co = (us >= (64'd1 << W));
            ss = sa + sb + longint'(c);
        end
        ov = (ss > S_MAX) || (ss < S_MIN);
        return {co, ov, us[W-1:0]};
    endfunction

    // Model: m_cyc counts cycles since acceptance (0 = idle).
    int           m_cyc;
    logic [W+1:0] m_pend;
    logic [W-1:0] m_sum;
    logic         m_cout, m_ovf, m_rv, m_sum_known;

    always @(posedge clk) begin
        if (rst) begin
            m_cyc <= 0; m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
            m_rv <= 1'b0; m_sum_known <= 1'b1;
        end else if (m_cyc == 0) begin
            if (bus.start) begin
                m_pend <= ref_op(bus.a_word, bus.b_word, bus.sub, bus.cin);
                m_cyc <= 1; m_rv <= 1'b0; m_sum_known <= 1'b0;
            end
        end else if (m_cyc <= N) begin
            if (bus.abort) m_cyc <= 0;
            else if (m_cyc == N) begin
                m_cyc <= N + 1;
                m_sum <= m_pend[W-1:0];
                m_ovf <= m_pend[W];
                m_cout <= m_pend[W+1];
                m_sum_known <= 1'b1;
            end else m_cyc <= m_cyc + 1;
        end else begin
            m_cyc <= 0; m_rv <= 1'b1;
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_busy", 64'(bus.busy), 64'(m_cyc != 0));
            chk("cmp_done", 64'(bus.done), 64'(m_cyc == N + 1));
            chk("cmp_result_valid", 64'(bus.result_valid), 64'(m_rv));
            chk("cmp_cout", 64'(bus.cout), 64'(m_cout));
            chk("cmp_ovf", 64'(bus.ovf), 64'(m_ovf));
            if (m_sum_known) chk("cmp_sum_word", 64'(bus.sum_word), 64'(m_sum));
        end
    end

    // One operation with literal expectations; optionally a second start during ADD.
    task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic c, input logic [W-1:0] es,
                         input logic eco, input logic eov, input bit spam);
        int nd, nb;
        logic [W-1:0] gs;
        logic gco, gov;
        nd = 0; nb = 0; gs = '0; gco = 1'b0; gov = 1'b0;
        bus.start = 1'b1; bus.a_word = a; bus.b_word = b; bus.sub = s; bus.cin = c;
        @(negedge clk);
        bus.start = 1'b0; bus.a_word = $urandom; bus.b_word = $urandom;
        bus.sub = ~s; bus.cin = ~c;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) begin
                nd++; gs = bus.sum_word; gco = bus.cout; gov = bus.ovf;
            end
            if (bus.busy) nb++;
            bus.start = (spam && i == 1);
            @(negedge clk);
        end
        chk({nm, "_done_count"}, 64'(nd), 64'd1);
        chk({nm, "_busy_cycles"}, 64'(nb), 64'(N + 1));
        chk({nm, "_sum"}, 64'(gs), 64'(es));
        chk({nm, "_cout"}, 64'(gco), 64'(eco));
        chk({nm, "_ovf"}, 64'(gov), 64'(eov));
        chk({nm, "_result_valid"}, 64'(bus.result_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] corners [4];
        int nd, last, gap;
        corners[0] = 32'h7FFF_FFFF; corners[1] = 32'h8000_0000;
        corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h0000_0000;
        n_chk = 0; n_fail = 0; chk_en = 1'b0;
        rst = 1'b1;
        bus.start = 1'b0; bus.sub = 1'b0; bus.cin = 1'b0; bus.abort = 1'b0;
        bus.a_word = '0; bus.b_word = '0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_result_valid", 64'(bus.result_valid), 64'd0);
        chk("reset_sum", 64'(bus.sum_word), 64'd0);
        chk("reset_cout", 64'(bus.cout), 64'd0);
        chk("reset_ovf", 64'(bus.ovf), 64'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);

        do_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        do_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        do_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        do_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        do_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        do_op("add_cin_spam", 32'h1234_5678, 32'h0000_FFFF, 1'b0, 1'b1, 32'h1235_5678, 1'b0, 1'b0, 1'b1);

        // Abort in the second ADD cycle.
        bus.start = 1'b1; bus.a_word = $urandom; bus.b_word = $urandom; bus.sub = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_result_valid", 64'(bus.result_valid), 64'd0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) nd++;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        do_op("after_abort", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // Reset mid-ADD with cout previously set.
        do_op("pre_rst", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b1; bus.a_word = 32'h7FFF_FFFF; bus.b_word = 32'h0000_0001;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_result_valid", 64'(bus.result_valid), 64'd0);
        chk("rst_sum", 64'(bus.sum_word), 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done) nd++;
            @(negedge clk);
        end
        chk("rst_no_done", 64'(nd), 64'd0);

        // Back-to-back with start held high.
        nd = 0; last = -1;
        bus.start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                if (last >= 0) begin
                    gap = i - last;
                    chk("b2b_spacing", 64'(gap), 64'(N + 2));
                end
                last = i; nd++;
            end
            bus.a_word = $urandom; bus.b_word = $urandom;
            bus.sub = 1'($urandom_range(0, 1)); bus.cin = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("b2b_done_count", 64'(nd), 64'd6);
        repeat (8) @(negedge clk);

        // Randomized traffic with aborts, stray starts and rare resets.
        for (int i = 0; i < 500; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.abort = ($urandom_range(0, 11) == 0);
            bus.sub = 1'($urandom_range(0, 1));
            bus.cin = 1'($urandom_range(0, 1));
            bus.a_word = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
            bus.b_word = ($urandom_range(0, 2) == 0) ? corners[$urandom_range(0, 3)] : W'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        repeat (10) @(negedge clk);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
